// File: rtl/fact_seq.sv
// Sequential factorial engine: multiplies an accumulator by the value of an
// external loadable down-counter until that counter signals its last step.
module fact_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  n,
  output logic        cnt_w,
  output logic [8:0]  cnt_ld,
  input  logic [8:0]  cnt_q,
  input  logic        cnt_end,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  n_q, n_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  // Full-width product so that bits lost by the 32-bit accumulator stay visible.
  logic [40:0] product;
  assign product = {9'd0, acc_q} * {32'd0, cnt_q};

  // NOTE: state registers update with non-blocking assignments only; all
  // combinational logic below uses blocking assignments with defaults first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= 9'd0;
      acc_q    <= 32'd1;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every variable gets a hold-value default before the case, which is
  // what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          acc_d   = 32'd1;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (n <= 9'd1) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        state_d = S_MUL;
      end

      S_MUL: begin
        // A counter reaching zero without ever flagging its last step is a fault.
        if ((cnt_q == 9'd0) && !cnt_end) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = product[31:0];
          if (product[40:32] != 9'd0) begin
            ovf_d = 1'b1;
          end
          if (cnt_end) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_w  = (state_q == S_LOAD);
  assign cnt_ld = n_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fact_seq.sv
// Self-checking bench for fact_seq: directed scenarios plus random operands,
// with an external down-counter model and an arithmetic factorial reference.
module tb_fact_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  n;
  logic        cnt_w;
  logic [8:0]  cnt_ld;
  logic [8:0]  cnt_q;
  logic        cnt_end;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        err;

  int checks   = 0;
  int failures = 0;

  bit stuck      = 1'b0;
  int w_count    = 0;
  int done_count = 0;
  logic [8:0] last_ld = 9'd0;

  fact_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n       (n),
    .cnt_w   (cnt_w),
    .cnt_ld  (cnt_ld),
    .cnt_q   (cnt_q),
    .cnt_end (cnt_end),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External loadable down-counter; in stuck mode it loads zero instead.
  always @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= 9'd0;
    else if (cnt_w)       cnt_q <= stuck ? 9'd0 : cnt_ld;
    else if (cnt_q != 0)  cnt_q <= cnt_q - 9'd1;
  end
  assign cnt_end = (cnt_q == 9'd1);

  // Pulse counters sampled on the rising edge, read by the main sequence on falling edges.
  always @(posedge clk) begin
    if (cnt_w) begin
      w_count <= w_count + 1;
      last_ld <= cnt_ld;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void fact_model(input int nv, input bit stk,
                                     output logic [31:0] r, output bit o, output bit e);
    longint unsigned a;
    longint unsigned p;
    a = 1;
    o = 1'b0;
    e = 1'b0;
    r = 32'd1;
    if (nv <= 1) return;
    if (stk) begin
      e = 1'b1;
      return;
    end
    for (int k = nv; k >= 1; k--) begin
      p = a * longint'(k);
      if ((p >> 32) != 0) o = 1'b1;
      a = p & 64'h0000_0000_FFFF_FFFF;
    end
    r = a[31:0];
  endfunction

  // Runs one operation from the accepting edge to the cycle after done.
  // pre_started: start/n already driven and the next rising edge accepts.
  // poke: assert start with another operand during MUL (must be ignored).
  // hold: leave start high through DONE for a back-to-back request.
  task automatic run_op(input int nv, input bit stk, input bit poke,
                        input bit hold, input bit pre_started);
    logic [31:0] er;
    bit eo, ee;
    int edges, exp_lat;
    stuck = stk;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      n     = 9'(nv);
    end
    w_count = 0;
    @(posedge clk);
    @(negedge clk);
    edges = 1;
    if (!hold) start = 1'b0;
    check("busy_after_accept", busy, 1);
    while (!done && edges < 600) begin
      if (poke && edges == 3) begin
        start = 1'b1;
        n     = 9'd9;
      end
      if (poke && edges == 5) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    exp_lat = (nv <= 1) ? 1 : (stk ? 3 : nv + 2);
    check("done_seen", done, 1);
    check("latency", edges, exp_lat);
    fact_model(nv, stk, er, eo, ee);
    @(posedge clk);
    @(negedge clk);
    check("result", result, er);
    check("ovf", ovf, eo);
    check("err", err, ee);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("cnt_w_pulses", w_count, (nv <= 1) ? 0 : 1);
    if (nv > 1) check("cnt_ld_value", last_ld, nv);
  endtask

  initial begin
    int dc;
    int nv;
    rst   = 1'b1;
    start = 1'b0;
    n     = 9'd0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt_w", cnt_w, 0);
    check("rst_cnt_ld", cnt_ld, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(5, 0, 0, 0, 0);
    check("n5_result", result, 120);
    run_op(0, 0, 0, 0, 0);
    run_op(1, 0, 0, 0, 0);
    run_op(12, 0, 0, 0, 0);
    check("n12_result", result, 479001600);
    run_op(13, 0, 0, 0, 0);
    check("n13_result", result, 1932053504);
    check("n13_ovf", ovf, 1);

    // Start asserted with another operand during MUL.
    run_op(5, 0, 1, 0, 0);
    check("poke_result", result, 120);

    // Counter stuck at zero after load.
    run_op(4, 1, 0, 0, 0);
    check("stuck_err", err, 1);

    // Back-to-back: start held through DONE, second operand taken in the next IDLE.
    run_op(3, 0, 0, 1, 0);
    n = 9'd4;
    run_op(4, 0, 0, 0, 1);
    check("b2b_result", result, 24);

    // Reset in the second MUL cycle of n = 8.
    stuck = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n     = 9'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cnt_w", cnt_w, 0);
    check("mid_rst_cnt_ld", cnt_ld, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_err", err, 0);
    dc = done_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", done_count, dc);
    run_op(3, 0, 0, 0, 0);
    check("after_rst_result", result, 6);

    // Random operands, mostly small with some large ones that wrap.
    for (int i = 0; i < 12; i++) begin
      nv = (i % 4 == 3) ? int'($urandom_range(14, 511)) : int'($urandom_range(0, 13));
      run_op(nv, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
